// File: rtl/stall_ctrl_pkg.sv
// Shared decode constants, FSM state encoding and stall-cause codes for the
// MIPS-lite pipeline interlock controller.
package stall_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN2_MUL  = 6'h01;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MDU_BUSY  = 2'd1,
    CTRL_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_LOAD_USE = 2'b01,
    CAUSE_MDU      = 2'b10,
    CAUSE_CTRL     = 2'b11
  } cause_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// ID-stage hazard inputs and front-end enable outputs of the stall controller.
interface stall_ctrl_if #(
  parameter int unsigned PERF_W = 16
);
  logic              id_valid;
  logic [31:0]       id_instr;
  logic              ex_mem_read;
  logic [4:0]        ex_rt;
  logic              en_pc;
  logic              en_ifid;
  logic              flush_ifid;
  logic              bubble_idex;
  logic [1:0]        stall_cause;
  logic              busy;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_instr, ex_mem_read, ex_rt,
    input  en_pc, en_ifid, flush_ifid, bubble_idex, stall_cause, busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_instr, ex_mem_read, ex_rt,
    output en_pc, en_ifid, flush_ifid, bubble_idex, stall_cause, busy, stall_cycles
  );
endinterface

// File: rtl/stall_ctrl_decode.sv
// Classifies the ID-stage instruction into MDU / HILO-read / control-transfer.
module instr_class_decode
  import stall_ctrl_pkg::*;
(
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  output logic        is_mdu,
  output logic        is_hilo,
  output logic        is_ctrl,
  output logic [4:0]  rs,
  output logic [4:0]  rt
);
  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op          = id_instr[31:26];
  assign fn          = id_instr[5:0];
  assign rs          = id_instr[25:21];
  assign rt          = id_instr[20:16];
  assign unused_bits = ^id_instr[15:6];

  always_comb begin
    is_mdu  = 1'b0;
    is_hilo = 1'b0;
    is_ctrl = 1'b0;
    if (id_valid) begin
      unique case (op)
        OP_SPECIAL: begin
          is_mdu  = (fn >= FN_MULT) && (fn <= FN_DIVU);
          is_hilo = (fn == FN_MFHI) || (fn == FN_MFLO);
          is_ctrl = (fn == FN_JR);
        end
        OP_SPECIAL2:                    is_mdu  = (fn == FN2_MUL);
        OP_J, OP_JAL, OP_BEQ, OP_BNE:   is_ctrl = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/stall_ctrl.sv
// Pipeline interlock controller: load-use interlock, counter-timed MDU and
// branch waits, and a saturating stall-cycle performance counter.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT      = 32,
  parameter int unsigned BR_STALL     = 2,
  parameter bit          MDU_BLOCKING = 1'b1,
  parameter int unsigned PERF_W       = 16
) (
  input logic         clk,
  input logic         rst,
  stall_ctrl_if.slave bus
);
  localparam int unsigned CNT_MAX   = max_u(MDU_LAT, BR_STALL);
  localparam int unsigned CW        = max_u($clog2(CNT_MAX + 1), 5);
  localparam int unsigned BR_RELOAD = (BR_STALL > 0) ? BR_STALL - 1 : 0;

  state_e            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic              busy_q;
  logic [PERF_W-1:0] stall_cycles_q;

  logic       is_mdu, is_hilo, is_ctrl;
  logic [4:0] rs, rt;
  logic       lu_hit;
  logic       en_pc, en_ifid, flush_ifid, bubble_idex;
  cause_e     cause;

  instr_class_decode u_decode (
    .id_instr (bus.id_instr),
    .id_valid (bus.id_valid),
    .is_mdu   (is_mdu),
    .is_hilo  (is_hilo),
    .is_ctrl  (is_ctrl),
    .rs       (rs),
    .rt       (rt)
  );

  assign lu_hit = bus.id_valid && bus.ex_mem_read && (bus.ex_rt != '0) &&
                  ((bus.ex_rt == rs) || (bus.ex_rt == rt));

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    en_pc       = 1'b1;
    en_ifid     = 1'b1;
    flush_ifid  = 1'b0;
    bubble_idex = 1'b0;
    cause       = CAUSE_NONE;
    // Outputs stay at their defaults while rst is high; the FSM is cleared by the register.
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (lu_hit) begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            bubble_idex = 1'b1;
            cause       = CAUSE_LOAD_USE;
          end else if (is_mdu) begin
            cnt_next   = CW'(MDU_LAT - 1);
            state_next = MDU_BUSY;
          end else if (is_ctrl && (BR_STALL > 0)) begin
            cnt_next   = CW'(BR_RELOAD);
            state_next = CTRL_WAIT;
          end
        end
        MDU_BUSY: begin
          if (MDU_BLOCKING || is_mdu || is_hilo || is_ctrl) begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            bubble_idex = 1'b1;
            cause       = CAUSE_MDU;
          end else if (lu_hit) begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            bubble_idex = 1'b1;
            cause       = CAUSE_LOAD_USE;
          end
          if (cnt == '0) state_next = IDLE;
          else           cnt_next   = cnt - 1'b1;
        end
        CTRL_WAIT: begin
          en_pc      = 1'b0;
          flush_ifid = 1'b1;
          cause      = CAUSE_CTRL;
          if (cnt == '0) state_next = IDLE;
          else           cnt_next   = cnt - 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      busy_q         <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      busy_q <= (state_next != IDLE);
      if (!en_pc && (stall_cycles_q != '1))
        stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign bus.en_pc        = en_pc;
  assign bus.en_ifid      = en_ifid;
  assign bus.flush_ifid   = flush_ifid;
  assign bus.bubble_idex  = bubble_idex;
  assign bus.stall_cause  = cause;
  assign bus.busy         = busy_q;
  assign bus.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl across four parameter builds.
module tb_stall_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADD  = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] I_SUB  = {6'h00, 5'd3, 5'd4, 5'd5, 5'd0, 6'h22};
  localparam logic [31:0] I_ZERO = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
  localparam logic [31:0] I_MULT = {6'h00, 5'd8, 5'd9, 10'd0, 6'h18};
  localparam logic [31:0] I_MFLO = {6'h00, 10'd0, 5'd10, 5'd0, 6'h12};
  localparam logic [31:0] I_BEQ  = {6'h04, 5'd1, 5'd2, 16'h0010};
  localparam logic [31:0] I_JR   = {6'h00, 5'd31, 15'd0, 6'h08};

  stall_ctrl_if #(.PERF_W(16)) ifa ();
  stall_ctrl_if #(.PERF_W(16)) ifb ();
  stall_ctrl_if #(.PERF_W(16)) ifc ();
  stall_ctrl_if #(.PERF_W(4))  ifd ();

  stall_ctrl #(.MDU_LAT(32), .BR_STALL(2), .MDU_BLOCKING(1'b1), .PERF_W(16))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  stall_ctrl #(.MDU_LAT(32), .BR_STALL(2), .MDU_BLOCKING(1'b0), .PERF_W(16))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  stall_ctrl #(.MDU_LAT(32), .BR_STALL(0), .MDU_BLOCKING(1'b1), .PERF_W(16))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));
  stall_ctrl #(.MDU_LAT(32), .BR_STALL(2), .MDU_BLOCKING(1'b1), .PERF_W(4))
    dut_d (.clk(clk), .rst(rst), .bus(ifd));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    ifa.id_valid = 1'b0; ifa.id_instr = '0; ifa.ex_mem_read = 1'b0; ifa.ex_rt = '0;
    ifb.id_valid = 1'b0; ifb.id_instr = '0; ifb.ex_mem_read = 1'b0; ifb.ex_rt = '0;
    ifc.id_valid = 1'b0; ifc.id_instr = '0; ifc.ex_mem_read = 1'b0; ifc.ex_rt = '0;
    ifd.id_valid = 1'b0; ifd.id_instr = '0; ifd.ex_mem_read = 1'b0; ifd.ex_rt = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_all();
    n_cmp++; if (ifa.en_pc !== 1'b1) begin n_fail++; $display("FAIL rst_en_pc: got %b want 1", ifa.en_pc); end
    n_cmp++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
    n_cmp++; if (ifa.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cycles: got %0d want 0", ifa.stall_cycles); end
    n_cmp++; if (ifd.stall_cycles !== 4'd0) begin n_fail++; $display("FAIL rst_stall_cycles_w4: got %0d want 0", ifd.stall_cycles); end
    // a load-use pattern while reset is held must not stall
    rst = 1'b1;
    ifa.id_valid = 1'b1; ifa.id_instr = I_ADD; ifa.ex_mem_read = 1'b1; ifa.ex_rt = 5'd8;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.en_ifid, ifa.bubble_idex, ifa.flush_ifid, ifa.stall_cause} !== 6'b110000)
      begin n_fail++; $display("FAIL rst_comb_outputs: got %b want 110000", {ifa.en_pc, ifa.en_ifid, ifa.bubble_idex, ifa.flush_ifid, ifa.stall_cause}); end
  endtask

  task automatic test_load_use();
    reset_all();
    ifa.id_valid = 1'b1; ifa.id_instr = I_ADD; ifa.ex_mem_read = 1'b1; ifa.ex_rt = 5'd8;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.en_ifid, ifa.bubble_idex, ifa.flush_ifid, ifa.stall_cause} !== 6'b001001)
      begin n_fail++; $display("FAIL lu_rs_hit: got %b want 001001", {ifa.en_pc, ifa.en_ifid, ifa.bubble_idex, ifa.flush_ifid, ifa.stall_cause}); end
    tick();
    ifa.ex_mem_read = 1'b0;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.bubble_idex, ifa.stall_cause} !== 4'b1000)
      begin n_fail++; $display("FAIL lu_release: got %b want 1000", {ifa.en_pc, ifa.bubble_idex, ifa.stall_cause}); end
    n_cmp++; if (ifa.stall_cycles !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cycles: got %0d want 1", ifa.stall_cycles); end
    ifa.ex_mem_read = 1'b1; ifa.ex_rt = 5'd9;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.stall_cause} !== 3'b001)
      begin n_fail++; $display("FAIL lu_rt_hit: got %b want 001", {ifa.en_pc, ifa.stall_cause}); end
    ifa.ex_rt = 5'd0; ifa.id_instr = I_ZERO;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.stall_cause} !== 3'b100)
      begin n_fail++; $display("FAIL lu_r0_no_stall: got %b want 100", {ifa.en_pc, ifa.stall_cause}); end
    ifa.ex_rt = 5'd8; ifa.id_instr = I_ADD; ifa.id_valid = 1'b0;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.stall_cause} !== 3'b100)
      begin n_fail++; $display("FAIL lu_invalid_no_stall: got %b want 100", {ifa.en_pc, ifa.stall_cause}); end
  endtask

  task automatic test_mdu_blocking();
    int stalls = 0;
    int bad = 0;
    reset_all();
    ifa.id_valid = 1'b1; ifa.id_instr = I_MULT;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.busy, ifa.stall_cause} !== 4'b1000)
      begin n_fail++; $display("FAIL mdu_issue: got %b want 1000", {ifa.en_pc, ifa.busy, ifa.stall_cause}); end
    tick();
    ifa.id_instr = I_ADD;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ifa.en_pc !== 1'b0) break;
      stalls++;
      if (ifa.stall_cause !== 2'b10 || ifa.busy !== 1'b1 || ifa.bubble_idex !== 1'b1) bad++;
      tick();
    end
    n_cmp++; if (stalls !== 32) begin n_fail++; $display("FAIL mdu_block_len: got %0d want 32", stalls); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL mdu_block_outputs: got %0d bad cycles want 0", bad); end
    n_cmp++; if (ifa.busy !== 1'b0) begin n_fail++; $display("FAIL mdu_block_busy_end: got %b want 0", ifa.busy); end
    n_cmp++; if (ifa.stall_cycles !== 16'd32) begin n_fail++; $display("FAIL mdu_block_perf: got %0d want 32", ifa.stall_cycles); end
  endtask

  task automatic test_mdu_nonblocking();
    int stalls = 0;
    int bad = 0;
    reset_all();
    ifb.id_valid = 1'b1; ifb.id_instr = I_MULT;
    tick();
    ifb.id_instr = I_ADD;
    #1;
    n_cmp++; if ({ifb.en_pc, ifb.busy, ifb.stall_cause} !== 4'b1100)
      begin n_fail++; $display("FAIL nb_add_pass: got %b want 1100", {ifb.en_pc, ifb.busy, ifb.stall_cause}); end
    tick();
    ifb.id_instr = I_SUB;
    #1;
    n_cmp++; if ({ifb.en_pc, ifb.busy, ifb.stall_cause} !== 4'b1100)
      begin n_fail++; $display("FAIL nb_sub_pass: got %b want 1100", {ifb.en_pc, ifb.busy, ifb.stall_cause}); end
    tick();
    ifb.id_instr = I_MFLO;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ifb.en_pc !== 1'b0) break;
      stalls++;
      if (ifb.stall_cause !== 2'b10) bad++;
      tick();
    end
    n_cmp++; if (stalls !== 30) begin n_fail++; $display("FAIL nb_mflo_hold: got %0d want 30", stalls); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL nb_mflo_cause: got %0d bad cycles want 0", bad); end
    n_cmp++; if ({ifb.busy, ifb.stall_cause} !== 3'b000)
      begin n_fail++; $display("FAIL nb_release: got %b want 000", {ifb.busy, ifb.stall_cause}); end
    n_cmp++; if (ifb.stall_cycles !== 16'd30) begin n_fail++; $display("FAIL nb_perf: got %0d want 30", ifb.stall_cycles); end
  endtask

  task automatic test_ctrl();
    int stalls = 0;
    int bad = 0;
    reset_all();
    ifa.id_valid = 1'b1; ifa.id_instr = I_BEQ;
    #1;
    n_cmp++; if (ifa.en_pc !== 1'b1) begin n_fail++; $display("FAIL br_issue: got %b want 1", ifa.en_pc); end
    tick();
    ifa.id_instr = I_ADD;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ifa.en_pc !== 1'b0) break;
      stalls++;
      if ({ifa.en_ifid, ifa.flush_ifid, ifa.bubble_idex, ifa.stall_cause} !== 5'b11011) bad++;
      tick();
    end
    n_cmp++; if (stalls !== 2) begin n_fail++; $display("FAIL br_wait_len: got %0d want 2", stalls); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL br_wait_outputs: got %0d bad cycles want 0", bad); end
    ifa.id_instr = I_JR;
    tick();
    ifa.id_instr = I_ADD;
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ifa.en_pc !== 1'b0) break;
      stalls++;
      tick();
    end
    n_cmp++; if (stalls !== 2) begin n_fail++; $display("FAIL jr_wait_len: got %0d want 2", stalls); end
    ifc.id_valid = 1'b1; ifc.id_instr = I_BEQ;
    tick();
    ifc.id_instr = I_ADD;
    #1;
    n_cmp++; if ({ifc.en_pc, ifc.flush_ifid, ifc.busy} !== 3'b100)
      begin n_fail++; $display("FAIL br0_no_wait: got %b want 100", {ifc.en_pc, ifc.flush_ifid, ifc.busy}); end
  endtask

  task automatic test_reset_abort();
    reset_all();
    ifa.id_valid = 1'b1; ifa.id_instr = I_MULT;
    tick();
    ifa.id_instr = I_ADD;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.bubble_idex, ifa.stall_cause} !== 4'b1000)
      begin n_fail++; $display("FAIL abort_comb: got %b want 1000", {ifa.en_pc, ifa.bubble_idex, ifa.stall_cause}); end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if ({ifa.en_pc, ifa.busy, ifa.stall_cause} !== 4'b1000)
      begin n_fail++; $display("FAIL abort_idle: got %b want 1000", {ifa.en_pc, ifa.busy, ifa.stall_cause}); end
    n_cmp++; if (ifa.stall_cycles !== 16'd0) begin n_fail++; $display("FAIL abort_perf: got %0d want 0", ifa.stall_cycles); end
  endtask

  task automatic test_perf_saturate();
    int exp_cnt = 0;
    logic exp_stall;
    reset_all();
    ifd.id_valid = 1'b1; ifd.id_instr = I_MULT;
    // MULT held in ID: issues at cycles 0 and 33, stalls in 1..32 and 34..65
    for (int i = 0; i <= 40; i++) begin
      #1;
      exp_stall = ((i >= 1) && (i <= 32)) || ((i >= 34) && (i <= 65));
      n_cmp++; if (ifd.en_pc !== !exp_stall)
        begin n_fail++; $display("FAIL sat_en_pc[%0d]: got %b want %b", i, ifd.en_pc, !exp_stall); end
      n_cmp++; if (ifd.stall_cycles !== 4'(exp_cnt))
        begin n_fail++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, ifd.stall_cycles, exp_cnt); end
      if (exp_stall && exp_cnt < 15) exp_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mdu_blocking();
    test_mdu_nonblocking();
    test_ctrl();
    test_reset_abort();
    test_perf_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
